// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte producers.
// Round-robin arbitration, one grant per byte frame. The winner's byte is latched, the
// transmitter is kicked with a one-cycle tx_start, and no new grant is issued until the
// transmitter's busy flag has risen and fallen again, or a busy-rise timeout has expired.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-low reset
//   req       per-requester request level, held until the matching gnt
//   req_data  requester i byte in bits [i*DATA_W +: DATA_W]
//   gnt       one-hot, one-cycle pulse: requester's byte accepted
//   tx_start  one-cycle pulse to the transmitter, tx_data valid with it
//   tx_data   latched byte, stable from grant until the arbiter is idle again
//   tx_busy   transmitter busy, high for the whole frame
//   owner     index of the current or most recent winner
//   active    high whenever the arbiter is not idle
//   err_to    one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT cycles
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       active,
  output logic                       err_to
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic              tx_start_q, tx_start_d;
  logic              err_to_q, err_to_d;
  logic [CntW-1:0]   to_cnt_q, to_cnt_d;

  // Unpacked view of the requesters' bytes.
  logic [DATA_W-1:0] req_bytes [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first set request scanning last+1, last+2, ... modulo NUM_REQ.
  // The sum is one bit wider so the modulo works for non-power-of-two NUM_REQ.
  logic [IdxW:0]   scan_sum;
  logic [IdxW-1:0] win_idx;
  logic            win_found;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_sum = {1'b0, last_q} + (IdxW+1)'(i);
      if (scan_sum >= (IdxW+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (IdxW+1)'(NUM_REQ);
      end
      if (!win_found && req[scan_sum[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    data_d     = data_q;
    gnt_d      = '0;
    tx_start_d = 1'b0;
    err_to_d   = 1'b0;
    to_cnt_d   = to_cnt_q;

    unique case (state_q)
      StIdle: begin
        // A busy transmitter here is a foreign or stale frame: hold off.
        if (win_found && !tx_busy) begin
          state_d = StIssue;
          owner_d = win_idx;
          data_d  = req_bytes[win_idx];
          gnt_d   = NUM_REQ'(1) << win_idx;
        end
      end
      StIssue: begin
        tx_start_d = 1'b1;
        to_cnt_d   = '0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (to_cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          // Advance the pointer anyway so a dead requester cannot starve the rest.
          err_to_d = 1'b1;
          last_d   = owner_q;
          state_d  = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_q     <= IdxW'(NUM_REQ - 1);
      owner_q    <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      err_to_q   <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      tx_start_q <= tx_start_d;
      err_to_q   <= err_to_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign tx_start = tx_start_q;
  assign tx_data  = data_q;
  assign owner    = owner_q;
  assign active   = (state_q != StIdle);
  assign err_to   = err_to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a transaction-timing model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 16;
  localparam int IdxW         = $clog2(NUM_REQ);

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      tx_busy = 1'b0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic [IdxW-1:0]           owner;
  logic                      active;
  logic                      err_to;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .owner    (owner),
    .active   (active),
    .err_to   (err_to)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Transmitter model ----------------
  int  frame_len = 4;
  bit  tx_dead = 1'b0;
  bit  force_busy = 1'b0;
  bit  rand_tx = 1'b0;
  int  tx_cnt = 0;
  int  cur_len = 0;
  int  cur_delay = 0;
  bit  cur_dead = 1'b0;

  always @(negedge clk) begin
    if (tx_cnt > 0) begin
      tx_busy = (tx_cnt <= cur_len);
      tx_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
    if (force_busy) tx_busy = 1'b1;
    if (tx_start === 1'b1) begin
      if (rand_tx) begin
        cur_len   = $urandom_range(1, 8);
        cur_delay = $urandom_range(0, 3);
        cur_dead  = ($urandom_range(0, 15) == 0);
      end else begin
        cur_len   = frame_len;
        cur_delay = 1;
        cur_dead  = tx_dead;
      end
      if (!cur_dead) tx_cnt = cur_len + cur_delay;
    end else if (rand_tx && tx_cnt == 0 && $urandom_range(0, 199) == 0) begin
      // Foreign frame not started by the arbiter.
      cur_len = 3;
      tx_cnt  = 3;
    end
  end

  // ---------------- Reference model ----------------
  // Timing is expressed as the age (in edges) since the grant edge: tx_start follows one
  // edge later, busy is watched from age 2, and the timeout lands at age BUSY_TIMEOUT+1.
  bit                        m_valid = 1'b0;
  bit                        m_idle = 1'b1;
  bit                        m_busy_seen = 1'b0;
  int                        m_last = NUM_REQ - 1;
  int                        m_owner = 0;
  int                        m_cyc = 0;
  int                        m_gedge = 0;
  int                        m_win;
  int                        m_age;
  logic [NUM_REQ-1:0]        m_sh;
  logic [NUM_REQ*DATA_W-1:0] m_dsh;
  logic [NUM_REQ-1:0]        e_gnt = '0;
  logic [DATA_W-1:0]         e_data = '0;
  bit                        e_start = 1'b0;
  bit                        e_err = 1'b0;

  always @(posedge clk) begin
    m_cyc++;
    e_gnt   = '0;
    e_start = 1'b0;
    e_err   = 1'b0;
    if (!reset) begin
      m_valid = 1'b1;
      m_idle  = 1'b1;
      m_last  = NUM_REQ - 1;
      m_owner = 0;
      e_data  = '0;
    end else if (m_valid) begin
      if (m_idle) begin
        if (req != '0 && !tx_busy) begin
          m_win = -1;
          for (int k = 1; k <= NUM_REQ; k++) begin
            m_sh = req >> ((m_last + k) % NUM_REQ);
            if (m_win < 0 && m_sh[0]) m_win = (m_last + k) % NUM_REQ;
          end
          m_idle      = 1'b0;
          m_owner     = m_win;
          m_gedge     = m_cyc;
          m_busy_seen = 1'b0;
          e_gnt       = NUM_REQ'(1) << m_win;
          m_dsh       = req_data >> (m_win * DATA_W);
          e_data      = m_dsh[DATA_W-1:0];
        end
      end else begin
        m_age = m_cyc - m_gedge;
        if (m_age == 1) begin
          e_start = 1'b1;
        end else if (!m_busy_seen) begin
          if (tx_busy) begin
            m_busy_seen = 1'b1;
          end else if (m_age == BUSY_TIMEOUT + 1) begin
            e_err  = 1'b1;
            m_last = m_owner;
            m_idle = 1'b1;
          end
        end else if (!tx_busy) begin
          m_last = m_owner;
          m_idle = 1'b1;
        end
      end
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt", gnt, e_gnt);
      chk("tx_start", tx_start, e_start);
      chk("tx_data", tx_data, e_data);
      chk("owner", owner, m_owner);
      chk("active", active, !m_idle);
      chk("err_to", err_to, e_err);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("gnt_with_start", (|gnt) && tx_start, 0);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic get_grant(input int budget, output int idx);
    idx = -1;
    for (int n = 0; n < budget && idx < 0; n++) begin
      step();
      if (gnt != '0) begin
        idx = $clog2(gnt);
        req = req & ~gnt;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && active !== 1'b0; n++) step();
    chk("wait_idle", active, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, required finish", $time);
    $fatal(1);
  end

  int idx;
  int order [5];
  int ng;
  int fall;
  int st;
  int et;
  bit prev_busy;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    step();
    step();
    reset = 1'b1;
    chk("rst_gnt", gnt, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_active", active, 0);
    chk("rst_err_to", err_to, 0);

    // 1: single requester, byte A5.
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    get_grant(10, idx);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_no_start_with_gnt", tx_start, 0);
    step();
    chk("t1_tx_start", tx_start, 1);
    chk("t1_gnt_clear", gnt, 0);
    chk("t1_tx_data", tx_data, 8'hA5);
    chk("t1_owner", owner, 0);
    wait_idle(100);

    // 2: all requesting, 20-cycle frames: rotation 0,1,2,3,0 with turnaround gap.
    pulse_reset();
    frame_len = 20;
    req = 4'b1111;
    ng = 0;
    fall = -1;
    prev_busy = tx_busy;
    for (int n = 0; n < 600 && ng < 5; n++) begin
      step();
      if (prev_busy && !tx_busy) fall = cyc;
      prev_busy = tx_busy;
      if (gnt != '0) begin
        order[ng] = $clog2(gnt);
        // Busy-low cycles up to and including the gnt cycle.
        if (ng > 0) chk("t2_gnt_gap_ge3", (cyc - fall + 1) >= 3, 1);
        ng++;
      end
    end
    chk("t2_grant_count", ng, 5);
    for (int k = 0; k < 5; k++) chk("t2_order", order[k], exp_order[k]);
    req = '0;
    wait_idle(100);

    // 3: last=2, req 0101 -> 0 (wrap) then 2.
    frame_len = 4;
    req = 4'b0100;
    get_grant(20, idx);
    chk("t3_setup_grant", idx, 2);
    wait_idle(100);
    req = 4'b0101;
    get_grant(20, idx);
    chk("t3_first", idx, 0);
    get_grant(100, idx);
    chk("t3_second", idx, 2);
    wait_idle(100);

    // 4: dead transmitter -> timeout, pointer still advances.
    tx_dead = 1'b1;
    req = 4'b0001;
    st = -1;
    et = -1;
    for (int n = 0; n < 100 && et < 0; n++) begin
      step();
      req = req & ~gnt;
      if (tx_start === 1'b1) st = cyc;
      if (err_to === 1'b1) begin
        et = cyc;
        chk("t4_idle_at_err", active, 0);
        chk("t4_owner", owner, 0);
      end
    end
    chk("t4_err_delay", et - st, BUSY_TIMEOUT);
    tx_dead = 1'b0;
    req = 4'b0011;
    get_grant(20, idx);
    chk("t4_next_winner", idx, 1);
    req = '0;
    wait_idle(100);

    // 5: reset during WAIT_DONE.
    frame_len = 10;
    req = 4'b0100;
    get_grant(20, idx);
    chk("t5_setup_grant", idx, 2);
    for (int n = 0; n < 20 && tx_busy !== 1'b1; n++) step();
    step();
    step();
    chk("t5_active_before_rst", active, 1);
    reset = 1'b0;
    step();
    chk("t5_gnt", gnt, 0);
    chk("t5_tx_start", tx_start, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_owner", owner, 0);
    chk("t5_active", active, 0);
    chk("t5_err_to", err_to, 0);
    reset = 1'b1;
    req = 4'b1001;
    get_grant(100, idx);
    chk("t5_post_reset_winner", idx, 0);
    req = '0;
    wait_idle(100);

    // 6: busy held in IDLE blocks the grant until it falls.
    frame_len = 4;
    force_busy = 1'b1;
    step();
    req = 4'b0010;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("t6_held_no_gnt", gnt, 0);
    end
    force_busy = 1'b0;
    step();
    chk("t6_busy_fell_no_gnt_yet", gnt, 0);
    step();
    chk("t6_gnt", gnt, 4'b0010);
    req = '0;
    wait_idle(100);

    // Randomized traffic.
    rand_tx = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 499) == 0) reset = 1'b0;
      req = req & ~gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && !gnt[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          end
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    rand_tx = 1'b0;
    req = '0;
    reset = 1'b1;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
